// File: rtl/cr16_pkg.sv
// CR16 shared definitions: PSR status bit positions and branch condition codes.
// Used by the ALU, the control unit and the PSR/condition unit.
package cr16_pkg;

  localparam int STATUS_WIDTH = 5;

  localparam int STATUS_INDEX_CARRY    = 0;
  localparam int STATUS_INDEX_LOW      = 1;
  localparam int STATUS_INDEX_FLAG     = 2;
  localparam int STATUS_INDEX_ZERO     = 3;
  localparam int STATUS_INDEX_NEGATIVE = 4;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/psr_cond_unit_if.sv
// ALU-status / control-unit side bundle of the PSR and condition unit.
// master drives updates and requests; slave holds the PSR and answers.
interface psr_cond_unit_if
  import cr16_pkg::*;
#(
   parameter int P_STATUS_WIDTH = STATUS_WIDTH
);

   logic [P_STATUS_WIDTH-1:0] I_STATUS;
   logic                      I_STATUS_WE;
   logic [P_STATUS_WIDTH-1:0] I_STATUS_MASK;
   logic                      I_PSR_WE;
   logic [P_STATUS_WIDTH-1:0] I_PSR_DATA;
   logic                      I_SAVE;
   logic                      I_RESTORE;
   logic                      I_COND_REQ;
   logic [3:0]                I_COND;
   logic [P_STATUS_WIDTH-1:0] O_PSR;
   logic                      O_COND_VALID;
   logic                      O_COND_TRUE;
   logic [2:0]                O_DEPTH;
   logic                      O_ERR;

   modport master (
      output I_STATUS, I_STATUS_WE, I_STATUS_MASK,
      output I_PSR_WE, I_PSR_DATA,
      output I_SAVE, I_RESTORE,
      output I_COND_REQ, I_COND,
      input  O_PSR, O_COND_VALID, O_COND_TRUE,
      input  O_DEPTH, O_ERR
   );

   modport slave (
      input  I_STATUS, I_STATUS_WE, I_STATUS_MASK,
      input  I_PSR_WE, I_PSR_DATA,
      input  I_SAVE, I_RESTORE,
      input  I_COND_REQ, I_COND,
      output O_PSR, O_COND_VALID, O_COND_TRUE,
      output O_DEPTH, O_ERR
   );

endinterface

// File: rtl/cond_eval.sv
// Combinational CR16 condition-code evaluator: (psr, cond) -> hit.
// Shared between the branch path here and the Scc path in the control unit.
module cond_eval
  import cr16_pkg::*;
#(
   parameter int P_STATUS_WIDTH = STATUS_WIDTH
) (
   input  logic [P_STATUS_WIDTH-1:0] psr,
   input  logic [3:0]                cond,
   output logic                      hit
);

   logic c, l, f, z, n;

   always_comb begin
      c = psr[STATUS_INDEX_CARRY];
      l = psr[STATUS_INDEX_LOW];
      f = psr[STATUS_INDEX_FLAG];
      z = psr[STATUS_INDEX_ZERO];
      n = psr[STATUS_INDEX_NEGATIVE];
      hit = 1'b0;
      unique case (cond)
         COND_EQ: hit = z;
         COND_NE: hit = !z;
         COND_CS: hit = c;
         COND_CC: hit = !c;
         COND_HI: hit = l;
         COND_LS: hit = !l;
         COND_GT: hit = n;
         COND_LE: hit = !n;
         COND_FS: hit = f;
         COND_FC: hit = !f;
         COND_LO: hit = !l && !z;
         COND_HS: hit = l || z;
         COND_LT: hit = !n && !z;
         COND_GE: hit = n || z;
         COND_UC: hit = 1'b1;
         COND_NV: hit = 1'b0;
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/psr_cond_unit.sv
// CR16 PSR register with save/restore shadow stack and registered
// branch condition evaluation against the next-state PSR.
module psr_cond_unit
  import cr16_pkg::*;
#(
   parameter int P_DEPTH        = 2,
   parameter int P_STATUS_WIDTH = STATUS_WIDTH
) (
   input  logic           I_CLK,
   input  logic           I_NRESET,
   psr_cond_unit_if.slave bus
);

   typedef logic [P_STATUS_WIDTH-1:0] psr_t;

   psr_t       psr_q;
   psr_t       psr_next;
   psr_t       top_entry;
   psr_t       stack_q [P_DEPTH];
   logic [2:0] depth_q;
   logic [2:0] depth_next;
   logic       full;
   logic       empty;
   logic       both;
   logic       do_push;
   logic       do_pop;
   logic       err_next;
   logic       hit;
   logic       cond_valid_q;
   logic       cond_true_q;
   logic       err_q;

   always_comb begin
      full     = (depth_q == 3'(P_DEPTH));
      empty    = (depth_q == 3'd0);
      both     = bus.I_SAVE && bus.I_RESTORE;
      do_push  = bus.I_SAVE && !bus.I_RESTORE && !full;
      do_pop   = bus.I_RESTORE && !bus.I_SAVE && !empty;
      err_next = both
               || (bus.I_SAVE && !bus.I_RESTORE && full)
               || (bus.I_RESTORE && !bus.I_SAVE && empty);

      top_entry = '0;
      for (int i = 0; i < P_DEPTH; i++) begin
         if (depth_q == 3'(i + 1)) top_entry = stack_q[i];
      end

      depth_next = depth_q;
      if (do_push) depth_next = depth_q + 3'd1;
      else if (do_pop) depth_next = depth_q - 3'd1;

      // Illegal restores fall through to the lower-priority sources.
      psr_next = psr_q;
      if (do_pop) begin
         psr_next = top_entry;
      end else if (bus.I_PSR_WE) begin
         psr_next = bus.I_PSR_DATA;
      end else if (bus.I_STATUS_WE) begin
         psr_next = (psr_q & ~bus.I_STATUS_MASK)
                  | (bus.I_STATUS & bus.I_STATUS_MASK);
      end
   end

   cond_eval #(
      .P_STATUS_WIDTH(P_STATUS_WIDTH)
   ) u_cond_eval (
      .psr  (psr_next),
      .cond (bus.I_COND),
      .hit  (hit)
   );

   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         psr_q        <= '0;
         depth_q      <= 3'd0;
         cond_valid_q <= 1'b0;
         cond_true_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         psr_q        <= psr_next;
         depth_q      <= depth_next;
         cond_valid_q <= bus.I_COND_REQ;
         cond_true_q  <= bus.I_COND_REQ && hit;
         err_q        <= err_next;
      end
   end

   // Push stores the pre-update PSR; pops leave the entry in place.
   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         for (int i = 0; i < P_DEPTH; i++) stack_q[i] <= '0;
      end else if (do_push) begin
         for (int i = 0; i < P_DEPTH; i++) begin
            if (depth_q == 3'(i)) stack_q[i] <= psr_q;
         end
      end
   end

   assign bus.O_PSR        = psr_q;
   assign bus.O_COND_VALID = cond_valid_q;
   assign bus.O_COND_TRUE  = cond_true_q;
   assign bus.O_DEPTH      = depth_q;
   assign bus.O_ERR        = err_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed plus random checks of psr_cond_unit against a queue-based
// PSR/condition reference model.
module tb_psr_cond_unit;

   localparam int DEPTH = 2;

   logic clk;
   logic nrst;
   int   n_vec;
   int   n_bad;

   int        m_psr;
   int        m_stack[$];
   bit        e_valid;
   bit        e_true;
   bit        e_err;

   psr_cond_unit_if bus ();

   psr_cond_unit #(
      .P_DEPTH(DEPTH),
      .P_STATUS_WIDTH(5)
   ) dut (
      .I_CLK    (clk),
      .I_NRESET (nrst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit cond_ref(int p, int c);
      bit cf, lf, ff, zf, nf;
      cf = p[0]; lf = p[1]; ff = p[2]; zf = p[3]; nf = p[4];
      case (c)
         0:  return zf;
         1:  return !zf;
         2:  return cf;
         3:  return !cf;
         4:  return lf;
         5:  return !lf;
         6:  return nf;
         7:  return !nf;
         8:  return ff;
         9:  return !ff;
         10: return !lf && !zf;
         11: return lf || zf;
         12: return !nf && !zf;
         13: return nf || zf;
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(string tag, int obs, int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.I_STATUS      = '0;
      bus.I_STATUS_WE   = 1'b0;
      bus.I_STATUS_MASK = '0;
      bus.I_PSR_WE      = 1'b0;
      bus.I_PSR_DATA    = '0;
      bus.I_SAVE        = 1'b0;
      bus.I_RESTORE     = 1'b0;
      bus.I_COND_REQ    = 1'b0;
      bus.I_COND        = '0;
   endtask

   // Apply current inputs for one clock, advance the model, check outputs.
   task automatic cycle(string tag);
      int  nxt;
      bit  popped;
      int  pv;
      popped = 0;
      pv     = 0;
      if (!nrst) begin
         m_psr = 0;
         m_stack.delete();
         e_valid = 0;
         e_true  = 0;
         e_err   = 0;
      end else begin
         e_err = 0;
         if (bus.I_SAVE && bus.I_RESTORE) e_err = 1;
         else if (bus.I_SAVE) begin
            if (m_stack.size() == DEPTH) e_err = 1;
            else m_stack.push_back(m_psr);
         end else if (bus.I_RESTORE) begin
            if (m_stack.size() == 0) e_err = 1;
            else begin
               pv = m_stack.pop_back();
               popped = 1;
            end
         end
         if (popped) nxt = pv;
         else if (bus.I_PSR_WE) nxt = int'(bus.I_PSR_DATA);
         else if (bus.I_STATUS_WE)
            nxt = (m_psr & ~int'(bus.I_STATUS_MASK))
                | (int'(bus.I_STATUS) & int'(bus.I_STATUS_MASK));
         else nxt = m_psr;
         m_psr   = nxt & 31;
         e_valid = bus.I_COND_REQ;
         e_true  = bus.I_COND_REQ && cond_ref(m_psr, int'(bus.I_COND));
      end
      @(posedge clk);
      #1;
      chk({tag, ".psr"},   int'(bus.O_PSR), m_psr);
      chk({tag, ".depth"}, int'(bus.O_DEPTH), m_stack.size());
      chk({tag, ".err"},   int'(bus.O_ERR), int'(e_err));
      chk({tag, ".valid"}, int'(bus.O_COND_VALID), int'(e_valid));
      chk({tag, ".true"},  int'(bus.O_COND_TRUE), int'(e_true));
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      m_psr = 0;
      e_valid = 0;
      e_true = 0;
      e_err = 0;
      nrst = 1'b0;
      idle();
      @(negedge clk);
      cycle("reset");
      chk("reset.psr0", int'(bus.O_PSR), 0);
      nrst = 1'b1;

      // Same-cycle compare and EQ branch.
      bus.I_STATUS_WE = 1; bus.I_STATUS_MASK = 5'h1F; bus.I_STATUS = 5'h08;
      bus.I_COND_REQ = 1; bus.I_COND = 4'd0;
      cycle("eq");
      chk("eq.true_c", int'(bus.O_COND_TRUE), 1);
      idle();

      // Masked update then LT/GE.
      bus.I_PSR_WE = 1; bus.I_PSR_DATA = 5'h11;
      cycle("ld11");
      idle();
      bus.I_STATUS_WE = 1; bus.I_STATUS_MASK = 5'h08; bus.I_STATUS = 5'h08;
      cycle("mask");
      chk("mask.psr_c", int'(bus.O_PSR), 5'h19);
      idle();
      bus.I_COND_REQ = 1; bus.I_COND = 4'd12;
      cycle("lt");
      bus.I_COND = 4'd13;
      cycle("ge");
      idle();

      // Explicit load wins over status update.
      bus.I_PSR_WE = 1; bus.I_PSR_DATA = 5'h04;
      bus.I_STATUS_WE = 1; bus.I_STATUS_MASK = 5'h1F; bus.I_STATUS = 5'h1F;
      bus.I_COND_REQ = 1; bus.I_COND = 4'd8;
      cycle("fs");
      chk("fs.psr_c", int'(bus.O_PSR), 5'h04);
      idle();
      bus.I_COND_REQ = 1; bus.I_COND = 4'd9;
      cycle("fc");
      idle();

      // Shadow stack fill, overflow, drain, underflow.
      bus.I_PSR_WE = 1; bus.I_PSR_DATA = 5'h03;
      cycle("ld03");
      idle();
      bus.I_SAVE = 1;
      cycle("save1");
      idle();
      bus.I_PSR_WE = 1; bus.I_PSR_DATA = 5'h1C;
      cycle("ld1c");
      idle();
      bus.I_SAVE = 1;
      cycle("save2");
      cycle("save3");
      chk("save3.err_c", int'(bus.O_ERR), 1);
      chk("save3.depth_c", int'(bus.O_DEPTH), 2);
      idle();
      bus.I_PSR_WE = 1; bus.I_PSR_DATA = 5'h00;
      cycle("ld00");
      idle();
      bus.I_RESTORE = 1;
      cycle("rest1");
      chk("rest1.psr_c", int'(bus.O_PSR), 5'h1C);
      cycle("rest2");
      chk("rest2.psr_c", int'(bus.O_PSR), 5'h03);
      cycle("rest3");
      chk("rest3.err_c", int'(bus.O_ERR), 1);
      idle();
      cycle("idle");

      // Save and restore together.
      bus.I_SAVE = 1;
      cycle("push");
      bus.I_RESTORE = 1;
      bus.I_STATUS_WE = 1; bus.I_STATUS_MASK = 5'h1F; bus.I_STATUS = 5'h1F;
      cycle("both");
      chk("both.psr_c", int'(bus.O_PSR), 5'h1F);
      chk("both.depth_c", int'(bus.O_DEPTH), 1);
      idle();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         nrst = ($urandom_range(0, 63) != 0);
         bus.I_STATUS      = 5'($urandom);
         bus.I_STATUS_WE   = 1'($urandom);
         bus.I_STATUS_MASK = 5'($urandom);
         bus.I_PSR_WE      = ($urandom_range(0, 3) == 0);
         bus.I_PSR_DATA    = 5'($urandom);
         bus.I_SAVE        = ($urandom_range(0, 3) == 0);
         bus.I_RESTORE     = ($urandom_range(0, 3) == 0);
         bus.I_COND_REQ    = 1'($urandom);
         bus.I_COND        = 4'($urandom);
         cycle("rnd");
      end
      nrst = 1'b1;
      idle();

      // Exhaustive PSR x condition sweep with a mid-sweep reset.
      for (int p = 0; p < 32; p++) begin
         for (int c = 0; c < 16; c++) begin
            nrst = !(p == 16 && c == 0);
            bus.I_PSR_WE   = 1;
            bus.I_PSR_DATA = 5'(p);
            bus.I_COND_REQ = 1;
            bus.I_COND     = 4'(c);
            cycle("sweep");
            if (p == 16 && c == 0)
               chk("sweep.rst_valid", int'(bus.O_COND_VALID), 0);
         end
      end
      nrst = 1'b1;
      idle();
      cycle("end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
